mvm_pingpong_sched: RTL

Sequencer and arbiter for the fp32 matrix-vector MAC datapath (fp_mult to fp_add, y accumulated in BRAM).
- Arbitrates PS requests for the two y half-buffers (A = rows 0..M/2-1, B = rows M/2..M-1).
- For the granted half, issues one MAC per cycle with pipeline-aligned W/x/y read and y write addressing.
- Reports per-half completion to PS over the AXI4-Lite control/status registers.
- Replaces the one-MAC-per-several-cycles FSM with a fully pipelined scheduler.

---
 rtl/mvm_pkg.sv | 29 ++
 rtl/mvm_pingpong_sched_if.sv | 27 ++
 rtl/mvm_pingpong_sched_delay.sv | 55 +++++
 rtl/mvm_pingpong_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and constants for the pipelined matrix-vector MAC scheduler.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        HALF_A = 1'b0,
        HALF_B = 1'b1
    } half_e;

    localparam int ST_DONE_A = 0;
    localparam int ST_DONE_B = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_ACTIVE = 3;

    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_MUL_LAT = 2;
    localparam int DEF_ADD_LAT = 2;
    localparam int PIPE_LAT    = DEF_RD_LAT + DEF_MUL_LAT + DEF_ADD_LAT;

    function automatic int pipe_lat(input int rd_lat, input int mul_lat, input int add_lat);
        return rd_lat + mul_lat + add_lat;
    endfunction

endpackage

// File: rtl/mvm_pingpong_sched_if.sv
// PS control/status registers and BRAM addressing bundle of the MAC scheduler.
interface mvm_pingpong_sched_if #(
    parameter int ADDR_W_SIZE = 16,
    parameter int ADDR_X_SIZE = 12,
    parameter int ADDR_Y_SIZE = 12
);
    logic [31:0]            ps_control;
    logic [31:0]            pl_status;
    logic [ADDR_W_SIZE-1:0] bram_addr_W;
    logic [ADDR_X_SIZE-1:0] bram_addr_x;
    logic [ADDR_Y_SIZE-1:0] bram_addr_y_rd;
    logic [ADDR_Y_SIZE-1:0] bram_addr_y_wr;
    logic [3:0]             bram_we_y;
    logic                   acc_zero;

    modport master (
        input  ps_control,
        output pl_status, bram_addr_W, bram_addr_x, bram_addr_y_rd,
               bram_addr_y_wr, bram_we_y, acc_zero
    );

    modport slave (
        output ps_control,
        input  pl_status, bram_addr_W, bram_addr_x, bram_addr_y_rd,
               bram_addr_y_wr, bram_we_y, acc_zero
    );
endinterface

// File: rtl/mvm_pingpong_sched_delay.sv
// Shift register carrying {valid, row, first} of each issued MAC down the
// read/multiply/add pipeline; stage 0 is the issue cycle itself.
module mvm_delay_line #(
    parameter int DEPTH   = 5,
    parameter int ROW_W   = 3,
    parameter int TAP_RD  = 2,
    parameter int TAP_ACC = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [ROW_W-1:0] in_row,
    input  logic             in_first,
    output logic             rd_valid,
    output logic [ROW_W-1:0] rd_row,
    output logic             acc_valid,
    output logic             acc_first,
    output logic             wr_valid,
    output logic [ROW_W-1:0] wr_row,
    output logic             upstream_busy
);
    logic [DEPTH:0]            valid_q, valid_d;
    logic [DEPTH:0]            first_q, first_d;
    logic [DEPTH:0][ROW_W-1:0] row_q, row_d;
    logic                      unused_taps;

    always_comb begin
        valid_d = {valid_q[DEPTH-1:0], in_valid};
        first_d = {first_q[DEPTH-1:0], in_first};
        row_d   = {row_q[DEPTH-1:0], in_row};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            first_q <= '0;
            row_q   <= '0;
        end else begin
            valid_q <= valid_d;
            first_q <= first_d;
            row_q   <= row_d;
        end
    end

    assign rd_valid  = valid_q[TAP_RD];
    assign rd_row    = row_q[TAP_RD];
    assign acc_valid = valid_q[TAP_ACC];
    assign acc_first = first_q[TAP_ACC];
    assign wr_valid  = valid_q[DEPTH];
    assign wr_row    = row_q[DEPTH];

    // The final write stage may still be in flight when draining completes.
    assign upstream_busy = |valid_q[DEPTH-1:0];
    assign unused_taps   = ^{first_q, row_q};
endmodule

// File: rtl/mvm_pingpong_sched.sv
// Ping-pong half-buffer arbiter and fully pipelined MAC issue scheduler:
// one W/x read per cycle, y read/zero/write aligned to the fp datapath.
module mvm_pingpong_sched
    import mvm_pkg::*;
#(
    parameter int LENGTH_M    = 128,
    parameter int LENGTH_N    = 128,
    parameter int ADDR_W_SIZE = 16,
    parameter int ADDR_X_SIZE = 12,
    parameter int ADDR_Y_SIZE = 12,
    parameter int RD_LAT      = 1,
    parameter int MUL_LAT     = 2,
    parameter int ADD_LAT     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mvm_pingpong_sched_if.master bus
);
    // state | meaning
    // IDLE  | arbitrate pending half requests
    // RUN   | issue one MAC per cycle, column-major over the granted half
    // DRAIN | wait for in-flight MACs to retire, then flag done

    localparam int HALF_M = LENGTH_M / 2;
    localparam int PL     = pipe_lat(RD_LAT, MUL_LAT, ADD_LAT);
    localparam int ROW_W  = (LENGTH_M > 1) ? $clog2(LENGTH_M) : 1;
    localparam int I_W    = (HALF_M > 1) ? $clog2(HALF_M) : 1;
    localparam int J_W    = (LENGTH_N > 1) ? $clog2(LENGTH_N) : 1;

    if ((LENGTH_M % 2 != 0) || (HALF_M < RD_LAT + ADD_LAT + 1)) begin : g_hazard
        $error("mvm_pingpong_sched: LENGTH_M must be even and LENGTH_M/2 >= RD_LAT+ADD_LAT+1");
    end

    state_e                 state_q, state_d;
    half_e                  active_q, active_d;
    half_e                  last_q, last_d;
    logic                   busy_q, busy_d;
    logic [1:0]             done_q, done_d;
    logic [I_W-1:0]         i_q, i_d;
    logic [J_W-1:0]         j_q, j_d;
    logic [ADDR_W_SIZE-1:0] addr_w_q, addr_w_d;
    logic [ADDR_X_SIZE-1:0] addr_x_q, addr_x_d;

    logic [1:0]             pend;
    logic [1:0]             done_set;
    logic                   issue;
    logic [ROW_W-1:0]       issue_row;
    logic                   issue_first;
    int                     row_int;

    logic                   dl_rd_valid, dl_acc_valid, dl_acc_first, dl_wr_valid, dl_busy;
    logic [ROW_W-1:0]       dl_rd_row, dl_wr_row;
    logic                   unused_ctrl;

    assign unused_ctrl = ^bus.ps_control[31:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            active_q <= HALF_A;
            last_q   <= HALF_B;
            busy_q   <= 1'b0;
            done_q   <= 2'b00;
            i_q      <= '0;
            j_q      <= '0;
            addr_w_q <= '0;
            addr_x_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            i_q      <= i_d;
            j_q      <= j_d;
            addr_w_q <= addr_w_d;
            addr_x_q <= addr_x_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        last_d   = last_q;
        busy_d   = busy_q;
        i_d      = i_q;
        j_d      = j_q;
        done_set = 2'b00;
        pend     = bus.ps_control[1:0] & ~done_q;
        unique case (state_q)
            IDLE: begin
                if (|pend) begin
                    if (&pend) active_d = (last_q == HALF_A) ? HALF_B : HALF_A;
                    else       active_d = pend[0] ? HALF_A : HALF_B;
                    i_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_q == I_W'(HALF_M - 1)) begin
                    i_d = '0;
                    if (j_q == J_W'(LENGTH_N - 1)) state_d = DRAIN;
                    else                           j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!dl_busy) begin
                    if (active_q == HALF_A) done_set[0] = 1'b1;
                    else                    done_set[1] = 1'b1;
                    busy_d  = 1'b0;
                    last_d  = active_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A completing half sets its done bit even if its request dropped this cycle.
        done_d = done_set | (done_q & bus.ps_control[1:0]);
    end

    always_comb begin
        issue       = (state_q == RUN);
        row_int     = int'(i_q) + ((active_q == HALF_B) ? HALF_M : 0);
        issue_row   = ROW_W'(row_int);
        issue_first = issue && (j_q == '0);
        addr_w_d    = issue ? ADDR_W_SIZE'((row_int * LENGTH_N + int'(j_q)) * 4) : '0;
        addr_x_d    = issue ? ADDR_X_SIZE'(int'(j_q) * 4) : '0;

        bus.pl_status            = '0;
        bus.pl_status[ST_DONE_A] = done_q[0];
        bus.pl_status[ST_DONE_B] = done_q[1];
        bus.pl_status[ST_BUSY]   = busy_q;
        bus.pl_status[ST_ACTIVE] = busy_q && (active_q == HALF_B);
    end

    mvm_delay_line #(
        .DEPTH   (PL),
        .ROW_W   (ROW_W),
        .TAP_RD  (MUL_LAT),
        .TAP_ACC (RD_LAT + MUL_LAT)
    ) u_delay (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (issue),
        .in_row        (issue_row),
        .in_first      (issue_first),
        .rd_valid      (dl_rd_valid),
        .rd_row        (dl_rd_row),
        .acc_valid     (dl_acc_valid),
        .acc_first     (dl_acc_first),
        .wr_valid      (dl_wr_valid),
        .wr_row        (dl_wr_row),
        .upstream_busy (dl_busy)
    );

    assign bus.bram_addr_W    = addr_w_q;
    assign bus.bram_addr_x    = addr_x_q;
    assign bus.bram_addr_y_rd = dl_rd_valid ? ADDR_Y_SIZE'({dl_rd_row, 2'b00}) : '0;
    assign bus.bram_addr_y_wr = dl_wr_valid ? ADDR_Y_SIZE'({dl_wr_row, 2'b00}) : '0;
    assign bus.bram_we_y      = dl_wr_valid ? 4'hf : 4'h0;
    assign bus.acc_zero       = dl_acc_valid && dl_acc_first;
endmodule
